// File: rtl/fsm.sv
// Row-buffer controller: fills three W-word rows into a 4-bank ring, then runs
// a W-cycle compute pass over the window and slides it by 1 or 2 rows.
module fsm #(
   parameter int W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic stride,
   output logic select_m0,
   output logic select_m1,
   output logic select_m2,
   output logic select_m3,
   output logic select0,
   output logic select1,
   output logic in_en,
   output logic pe_rst
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t state, state_nxt;
   logic [CW-1:0] col, col_nxt;
   logic [1:0] wr_ptr, wr_ptr_nxt;
   logic [1:0] rd_ptr, rd_ptr_nxt;
   logic [1:0] rows_left, rows_left_nxt;
   logic [3:0] select_m;
   logic [1:0] sel;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         col       <= '0;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         rows_left <= 2'd0;
      end else begin
         state     <= state_nxt;
         col       <= col_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         rows_left <= rows_left_nxt;
      end
   end

   // Bank write enables follow the strobe during FILL; everything else is state-decoded.
   always_comb begin
      state_nxt     = state;
      col_nxt       = col;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      rows_left_nxt = rows_left;
      select_m      = 4'b0000;
      sel           = 2'd0;
      in_en         = 1'b0;
      pe_rst        = 1'b0;
      case (state)
         IDLE: begin
            pe_rst = 1'b1;
            if (in) begin
               state_nxt     = FILL;
               rows_left_nxt = 2'd3;
               col_nxt       = '0;
            end
         end
         FILL: begin
            in_en = 1'b1;
            sel   = rd_ptr;
            if (in) begin
               select_m[wr_ptr] = 1'b1;
               if (col == COL_LAST) begin
                  col_nxt       = '0;
                  wr_ptr_nxt    = wr_ptr + 2'd1;
                  rows_left_nxt = rows_left - 2'd1;
                  if (rows_left == 2'd1)
                     state_nxt = RUN;
               end else begin
                  col_nxt = col + CW'(1);
               end
            end
         end
         RUN: begin
            sel    = rd_ptr;
            pe_rst = (col == '0);
            if (col == COL_LAST) begin
               col_nxt       = '0;
               rd_ptr_nxt    = rd_ptr + {1'b0, stride} + 2'd1;
               rows_left_nxt = {1'b0, stride} + 2'd1;
               state_nxt     = FILL;
            end else begin
               col_nxt = col + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign select_m0 = select_m[0];
   assign select_m1 = select_m[1];
   assign select_m2 = select_m[2];
   assign select_m3 = select_m[3];
   assign select0   = sel[0];
   assign select1   = sel[1];

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: a word/row-count reference model predicts every
// output cycle under directed and randomized strobe/stride/reset sequences.
module tb_fsm;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in = 1'b0;
   logic stride = 1'b0;
   logic select_m0, select_m1, select_m2, select_m3;
   logic select0, select1, in_en, pe_rst;

   int checks = 0;
   int errors = 0;

   fsm #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .stride(stride),
      .select_m0(select_m0), .select_m1(select_m1),
      .select_m2(select_m2), .select_m3(select_m3),
      .select0(select0), .select1(select1),
      .in_en(in_en), .pe_rst(pe_rst)
   );

   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 filling, 2 computing; tracks words and rows, not pointers.
   int m_mode;
   int m_words_needed;
   int m_words_done;
   int m_rows_written;
   int m_window_base;
   int m_run_cycle;
   logic [7:0] exp_out;
   wire  [7:0] dut_out = {select_m3, select_m2, select_m1, select_m0,
                          select1, select0, in_en, pe_rst};

   function automatic void model_reset();
      m_mode = 0; m_words_needed = 0; m_words_done = 0;
      m_rows_written = 0; m_window_base = 0; m_run_cycle = 0;
   endfunction

   function automatic void model_expect();
      logic [3:0] bank;
      logic [1:0] base;
      bank = 4'b0000;
      base = 2'(m_window_base % 4);
      case (m_mode)
         0: exp_out = 8'b0000_00_0_1;
         1: begin
            if (in) bank[m_rows_written % 4] = 1'b1;
            exp_out = {bank, base, 1'b1, 1'b0};
         end
         default: exp_out = {4'b0000, base, 1'b0, (m_run_cycle == 0)};
      endcase
   endfunction

   function automatic void model_advance();
      if (rst_n) begin
         model_reset();
         return;
      end
      case (m_mode)
         0: if (in) begin
            m_mode = 1; m_words_needed = 3 * W; m_words_done = 0;
         end
         1: if (in) begin
            m_words_done++;
            if (m_words_done % W == 0) m_rows_written++;
            if (m_words_done == m_words_needed) begin
               m_mode = 2; m_run_cycle = 0;
            end
         end
         default: begin
            m_run_cycle++;
            if (m_run_cycle == W) begin
               m_window_base += stride + 1;
               m_words_needed = (stride + 1) * W;
               m_words_done = 0;
               m_mode = 1;
            end
         end
      endcase
   endfunction

   task automatic drive(input logic i, input logic s, input logic r);
      @(negedge clk);
      in = i; stride = s; rst_n = r;
      #1;
      model_expect();
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1'b1);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         checks++;
         if (dut_out !== exp_out || dut_out !== 8'b0000_00_0_1) begin
            errors++;
            $display("[TB] FAIL reset cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_idle_hold();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL idle_hold cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_stride(input logic s, input int cycles);
      drive(1'b0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < cycles; k++) begin
         drive(1'b1, s, 1'b0);
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL stride%0d cyc %0d: got %b expected %b", s, k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_toggle();
      drive(1'b0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 48; k++) begin
         drive(1'(k % 2 == 0), 1'($urandom_range(0, 1)), 1'b0);
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL toggle cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_partial_fill();
      drive(1'b0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 20; k++) begin
         drive(1'(k < 10), 1'b0, 1'b0);
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL partial_fill cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
      checks++;
      if (in_en !== 1'b1 || select_m2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL partial_stall: in_en=%b select_m2=%b expected 1 and 0", in_en, select_m2);
      end
   endtask

   task automatic test_mid_run_reset();
      drive(1'b0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 24; k++) begin
         drive(1'b1, 1'b1, 1'(k == 15));
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL mid_run_reset cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 99) == 0));
         checks++;
         if (dut_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL random cyc %0d: got %b expected %b", k, dut_out, exp_out);
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_hold();
      test_stride(1'b0, 1 + 12 + 4 + 4 + 4 + 4 + 4 + 4);
      test_stride(1'b1, 1 + 12 + 4 + 8 + 4 + 8 + 4);
      test_toggle();
      test_partial_fill();
      test_mid_run_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
